bin2seg_conv: RTL and testbench



---
 rtl/bin2seg_conv.sv | 156 +++++++++++++++
 tb/tb_bin2seg_conv.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2seg_conv.sv
// Sequential binary to seven-segment converter. Double-dabble runs one bit per clock behind a
// start/done handshake and adds leading-zero blanking and an overflow dash display.
module bin2seg_conv #(
   parameter int unsigned BIN_W          = 6,
   parameter int unsigned DIGITS         = 2,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          LEAD_BLANK     = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [BIN_W-1:0]    bin_val,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] bcd,
   output logic [7*DIGITS-1:0] seg,
   output logic                overflow
);
   localparam int unsigned CNT_W    = $clog2(BIN_W + 1);
   localparam int unsigned ACC_W    = 4 * DIGITS;
   localparam logic [6:0]  SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
   localparam logic [6:0]  SEG_DASH = SEG_ACTIVE_LOW ? 7'h3f : 7'h40;

   typedef enum logic [1:0] {StIdle, StShift, StUpdate} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [BIN_W-1:0]    r_bin;
   logic [ACC_W-1:0]    r_acc;
   logic [ACC_W-1:0]    w_acc_adj;
   logic [ACC_W-1:0]    w_acc_shift;
   logic                w_carry;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_ovf_sticky;
   logic [ACC_W-1:0]    r_bcd;
   logic [7*DIGITS-1:0] r_seg;
   logic [7*DIGITS-1:0] w_seg;
   logic                r_ovf;
   logic                r_done;
   logic                w_upper_zero;
   logic [3:0]          w_digit;
   logic [6:0]          w_pat;

   // Active-low gfedcba pattern for one decimal digit.
   function automatic logic [6:0] f_seg_al(input logic [3:0] d);
      logic [6:0] p;
      unique case (d)
         4'd0:    p = 7'b1000000;
         4'd1:    p = 7'b1111001;
         4'd2:    p = 7'b0100100;
         4'd3:    p = 7'b0110000;
         4'd4:    p = 7'b0011001;
         4'd5:    p = 7'b0010010;
         4'd6:    p = 7'b0000010;
         4'd7:    p = 7'b1111000;
         4'd8:    p = 7'b0000000;
         4'd9:    p = 7'b0010000;
         default: p = 7'b1111111;
      endcase
      return p;
   endfunction

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:   if (start) w_state_next = StShift;
         StShift:  if (r_cnt == CNT_W'(1)) w_state_next = StUpdate;
         StUpdate: w_state_next = StIdle;
         default:  w_state_next = StIdle;
      endcase
   end

   // Add-3 correction keeps every digit in 0..9 after the shift; the top digit's
   // carry-out counts multiples of 10^DIGITS and is what flags overflow.
   always_comb begin
      w_acc_adj = r_acc;
      for (int k = 0; k < int'(DIGITS); k++) begin
         if (r_acc[4*k +: 4] >= 4'd5) w_acc_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
      end
   end

   assign w_acc_shift = {w_acc_adj[ACC_W-2:0], r_bin[BIN_W-1]};
   assign w_carry     = w_acc_adj[ACC_W-1];

   always_comb begin
      w_seg        = '0;
      w_upper_zero = 1'b1;
      w_digit      = '0;
      w_pat        = '0;
      for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
         w_digit = r_acc[4*k +: 4];
         if (r_ovf_sticky) begin
            w_pat = SEG_DASH;
         end else if (LEAD_BLANK && (k != 0) && w_upper_zero && (w_digit == 4'd0)) begin
            w_pat = SEG_OFF;
         end else begin
            w_pat = SEG_ACTIVE_LOW ? f_seg_al(w_digit) : ~f_seg_al(w_digit);
         end
         if (w_digit != 4'd0) w_upper_zero = 1'b0;
         w_seg[7*k +: 7] = w_pat;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bin        <= '0;
         r_acc        <= '0;
         r_cnt        <= '0;
         r_ovf_sticky <= 1'b0;
         r_bcd        <= '0;
         r_seg        <= {DIGITS{SEG_OFF}};
         r_ovf        <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (start) begin
                  r_bin        <= bin_val;
                  r_acc        <= '0;
                  r_cnt        <= CNT_W'(BIN_W);
                  r_ovf_sticky <= 1'b0;
               end
            end
            StShift: begin
               r_acc <= w_acc_shift;
               r_bin <= r_bin << 1;
               r_cnt <= r_cnt - CNT_W'(1);
               if (w_carry) r_ovf_sticky <= 1'b1;
            end
            StUpdate: begin
               r_bcd  <= r_acc;
               r_seg  <= w_seg;
               r_ovf  <= r_ovf_sticky;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy     = (r_state != StIdle);
   assign done     = r_done;
   assign bcd      = r_bcd;
   assign seg      = r_seg;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_bin2seg_conv.sv
// Bench for bin2seg_conv: five parameter variants checked against a decimal-arithmetic
// reference model, covering latency, back-to-back, ignored starts and async reset.
module tb_bin2seg_conv;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        wstart = 1'b0;
   logic [5:0]  bin_val = '0;
   logic [13:0] wbin = '0;

   int n_cmp = 0;
   int n_bad = 0;

   // cfg 0 default, 1 DIGITS=1, 2 LEAD_BLANK, 3 active-high, 4 wide (14b, 4 digits, blanking)
   int unsigned cfg_nd [5] = '{2, 1, 2, 2, 4};
   bit          cfg_al [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
   bit          cfg_lb [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   logic        busy0, busy1, busy2, busy3, busy4;
   logic        done0, done1, done2, done3, done4;
   logic        ovf0, ovf1, ovf2, ovf3, ovf4;
   logic [7:0]  bcd0, bcd2, bcd3;
   logic [3:0]  bcd1;
   logic [15:0] bcd4;
   logic [13:0] seg0, seg2, seg3;
   logic [6:0]  seg1;
   logic [27:0] seg4;

   logic [4:0]  a_busy, a_done, a_ovf;
   logic [19:0] a_bcd [5];
   logic [34:0] a_seg [5];

   assign a_busy = {busy4, busy3, busy2, busy1, busy0};
   assign a_done = {done4, done3, done2, done1, done0};
   assign a_ovf  = {ovf4, ovf3, ovf2, ovf1, ovf0};
   assign a_bcd[0] = 20'(bcd0);
   assign a_bcd[1] = 20'(bcd1);
   assign a_bcd[2] = 20'(bcd2);
   assign a_bcd[3] = 20'(bcd3);
   assign a_bcd[4] = 20'(bcd4);
   assign a_seg[0] = 35'(seg0);
   assign a_seg[1] = 35'(seg1);
   assign a_seg[2] = 35'(seg2);
   assign a_seg[3] = 35'(seg3);
   assign a_seg[4] = 35'(seg4);

   bin2seg_conv #(.BIN_W(6), .DIGITS(2), .SEG_ACTIVE_LOW(1'b1), .LEAD_BLANK(1'b0)) u_def (
      .clk(clk), .rst(rst), .start(start), .bin_val(bin_val), .busy(busy0), .done(done0),
      .bcd(bcd0), .seg(seg0), .overflow(ovf0));
   bin2seg_conv #(.BIN_W(6), .DIGITS(1), .SEG_ACTIVE_LOW(1'b1), .LEAD_BLANK(1'b0)) u_d1 (
      .clk(clk), .rst(rst), .start(start), .bin_val(bin_val), .busy(busy1), .done(done1),
      .bcd(bcd1), .seg(seg1), .overflow(ovf1));
   bin2seg_conv #(.BIN_W(6), .DIGITS(2), .SEG_ACTIVE_LOW(1'b1), .LEAD_BLANK(1'b1)) u_lb (
      .clk(clk), .rst(rst), .start(start), .bin_val(bin_val), .busy(busy2), .done(done2),
      .bcd(bcd2), .seg(seg2), .overflow(ovf2));
   bin2seg_conv #(.BIN_W(6), .DIGITS(2), .SEG_ACTIVE_LOW(1'b0), .LEAD_BLANK(1'b0)) u_ah (
      .clk(clk), .rst(rst), .start(start), .bin_val(bin_val), .busy(busy3), .done(done3),
      .bcd(bcd3), .seg(seg3), .overflow(ovf3));
   bin2seg_conv #(.BIN_W(14), .DIGITS(4), .SEG_ACTIVE_LOW(1'b1), .LEAD_BLANK(1'b1)) u_wide (
      .clk(clk), .rst(rst), .start(wstart), .bin_val(wbin), .busy(busy4), .done(done4),
      .bcd(bcd4), .seg(seg4), .overflow(ovf4));

   always #5 clk = ~clk;

   // Reference: decimal digits by division, display rules applied per digit.
   function automatic void model(input int unsigned v, input int unsigned nd, input bit al,
                                 input bit lb, output logic [19:0] e_bcd,
                                 output logic [34:0] e_seg, output logic e_ovf);
      logic [6:0]  tbl [10];
      logic [6:0]  pat;
      int unsigned d;
      int          msd;
      tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      e_bcd = '0;
      e_seg = '0;
      e_ovf = (v >= 10 ** nd);
      msd   = 0;
      for (int k = 0; k < int'(nd); k++) begin
         d = (v / (10 ** k)) % 10;
         if (d != 0) msd = k;
      end
      for (int k = 0; k < int'(nd); k++) begin
         d = (v / (10 ** k)) % 10;
         e_bcd[4*k +: 4] = 4'(d);
         if (e_ovf) pat = 7'b0111111;
         else if (lb && (k > msd)) pat = 7'b1111111;
         else pat = tbl[d];
         if (!al) pat = ~pat;
         e_seg[7*k +: 7] = pat;
      end
   endfunction

   task automatic do_conv(input bit wide, input int unsigned v, output int lat,
                          output logic busy_seen);
      if (wide) begin
         wstart = 1'b1;
         wbin   = 14'(v);
      end else begin
         start   = 1'b1;
         bin_val = 6'(v);
      end
      @(posedge clk);
      #1;
      start     = 1'b0;
      wstart    = 1'b0;
      busy_seen = wide ? a_busy[4] : a_busy[0];
      lat       = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (wide ? a_done[4] : a_done[0]) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [34:0] e_seg;
      repeat (2) @(posedge clk);
      #1;
      for (int c = 0; c < 5; c++) begin
         e_seg = '0;
         for (int k = 0; k < int'(cfg_nd[c]); k++) e_seg[7*k +: 7] = cfg_al[c] ? 7'h7f : 7'h00;
         n_cmp++;
         if (a_busy[c] !== 1'b0 || a_done[c] !== 1'b0 || a_ovf[c] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctl cfg%0d: busy=%b done=%b ovf=%b, want 000", c, a_busy[c],
                     a_done[c], a_ovf[c]);
         end
         n_cmp++;
         if (a_bcd[c] !== 20'h0 || a_seg[c] !== e_seg) begin
            n_bad++;
            $display("FAIL reset_data cfg%0d: bcd=%h seg=%b, want bcd=0 seg=%b", c, a_bcd[c],
                     a_seg[c], e_seg);
         end
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single();
      int unsigned vals [4] = '{59, 42, 7, 0};
      int          lat;
      logic        bs;
      logic [19:0] e_bcd;
      logic [34:0] e_seg;
      logic        e_ovf;
      foreach (vals[j]) begin
         @(negedge clk);
         do_conv(1'b0, vals[j], lat, bs);
         n_cmp++;
         if (lat != 7 || bs !== 1'b1 || a_done[3:0] !== 4'hf) begin
            n_bad++;
            $display("FAIL single_lat v=%0d: lat=%0d busy=%b done=%b, want lat=7 busy=1 done=1111",
                     vals[j], lat, bs, a_done[3:0]);
         end
         for (int c = 0; c < 4; c++) begin
            model(vals[j], cfg_nd[c], cfg_al[c], cfg_lb[c], e_bcd, e_seg, e_ovf);
            n_cmp++;
            if (a_bcd[c] !== e_bcd || a_seg[c] !== e_seg || a_ovf[c] !== e_ovf) begin
               n_bad++;
               $display("FAIL single_out cfg%0d v=%0d: bcd=%h seg=%b ovf=%b, want %h %b %b", c,
                        vals[j], a_bcd[c], a_seg[c], a_ovf[c], e_bcd, e_seg, e_ovf);
            end
         end
         @(posedge clk);
         #1;
         n_cmp++;
         if (a_done[3:0] !== 4'h0) begin
            n_bad++;
            $display("FAIL single_pulse v=%0d: done=%b, want 0000", vals[j], a_done[3:0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int          lat;
      logic        bs;
      logic [19:0] e_bcd;
      logic [34:0] e_seg;
      logic        e_ovf;
      @(negedge clk);
      for (int v = 0; v < 64; v++) begin
         do_conv(1'b0, v, lat, bs);
         n_cmp++;
         if (lat != 7 || a_busy[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_lat v=%0d: lat=%0d busy=%b, want lat=7 busy=0", v, lat, a_busy[0]);
         end
         for (int c = 0; c < 4; c++) begin
            model(v, cfg_nd[c], cfg_al[c], cfg_lb[c], e_bcd, e_seg, e_ovf);
            n_cmp++;
            if (a_bcd[c] !== e_bcd || a_seg[c] !== e_seg || a_ovf[c] !== e_ovf) begin
               n_bad++;
               $display("FAIL b2b_out cfg%0d v=%0d: bcd=%h seg=%b ovf=%b, want %h %b %b", c, v,
                        a_bcd[c], a_seg[c], a_ovf[c], e_bcd, e_seg, e_ovf);
            end
         end
      end
   endtask

   task automatic test_start_ignored();
      int unsigned v1, v2;
      int          lat, extra;
      logic [19:0] e_bcd;
      logic [34:0] e_seg;
      logic        e_ovf;
      v1 = $urandom_range(0, 63);
      v2 = v1 ^ 6'h2a;
      @(negedge clk);
      start   = 1'b1;
      bin_val = 6'(v1);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      start   = 1'b1;
      bin_val = 6'(v2);
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 0;
      for (int i = 4; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (a_done[0]) begin
            lat = i;
            break;
         end
      end
      extra = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (a_done[0]) extra++;
      end
      n_cmp++;
      if (lat != 7 || extra != 0) begin
         n_bad++;
         $display("FAIL ignore_start v1=%0d v2=%0d: lat=%0d extra_done=%0d, want 7 and 0", v1, v2,
                  lat, extra);
      end
      for (int c = 0; c < 4; c++) begin
         model(v1, cfg_nd[c], cfg_al[c], cfg_lb[c], e_bcd, e_seg, e_ovf);
         n_cmp++;
         if (a_bcd[c] !== e_bcd || a_seg[c] !== e_seg || a_ovf[c] !== e_ovf) begin
            n_bad++;
            $display("FAIL ignore_out cfg%0d v1=%0d: bcd=%h seg=%b ovf=%b, want %h %b %b", c, v1,
                     a_bcd[c], a_seg[c], a_ovf[c], e_bcd, e_seg, e_ovf);
         end
      end
   endtask

   task automatic test_random();
      int unsigned v;
      int          lat;
      logic        bs;
      logic [19:0] e_bcd;
      logic [34:0] e_seg;
      logic        e_ovf;
      for (int n = 0; n < 30; n++) begin
         v = $urandom_range(0, 63);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_conv(1'b0, v, lat, bs);
         n_cmp++;
         if (lat != 7 || bs !== 1'b1) begin
            n_bad++;
            $display("FAIL rand_lat v=%0d: lat=%0d busy=%b, want 7 and 1", v, lat, bs);
         end
         for (int c = 0; c < 4; c++) begin
            model(v, cfg_nd[c], cfg_al[c], cfg_lb[c], e_bcd, e_seg, e_ovf);
            n_cmp++;
            if (a_bcd[c] !== e_bcd || a_seg[c] !== e_seg || a_ovf[c] !== e_ovf) begin
               n_bad++;
               $display("FAIL rand_out cfg%0d v=%0d: bcd=%h seg=%b ovf=%b, want %h %b %b", c, v,
                        a_bcd[c], a_seg[c], a_ovf[c], e_bcd, e_seg, e_ovf);
            end
         end
      end
   endtask

   task automatic test_wide();
      int unsigned v;
      int          lat;
      logic        bs;
      logic [19:0] e_bcd;
      logic [34:0] e_seg;
      logic        e_ovf;
      for (int n = 0; n < 24; n++) begin
         case (n)
            0: v = 0;
            1: v = 9999;
            2: v = 10000;
            3: v = 16383;
            4: v = 105;
            default: v = $urandom_range(0, 16383);
         endcase
         @(negedge clk);
         do_conv(1'b1, v, lat, bs);
         n_cmp++;
         if (lat != 15 || bs !== 1'b1) begin
            n_bad++;
            $display("FAIL wide_lat v=%0d: lat=%0d busy=%b, want 15 and 1", v, lat, bs);
         end
         model(v, cfg_nd[4], cfg_al[4], cfg_lb[4], e_bcd, e_seg, e_ovf);
         n_cmp++;
         if (a_bcd[4] !== e_bcd || a_seg[4] !== e_seg || a_ovf[4] !== e_ovf) begin
            n_bad++;
            $display("FAIL wide_out v=%0d: bcd=%h seg=%b ovf=%b, want %h %b %b", v, a_bcd[4],
                     a_seg[4], a_ovf[4], e_bcd, e_seg, e_ovf);
         end
      end
   endtask

   task automatic test_reset_mid();
      int          lat, seen;
      logic        bs;
      logic [19:0] e_bcd;
      logic [34:0] e_seg;
      logic        e_ovf;
      @(negedge clk);
      do_conv(1'b0, 59, lat, bs);
      start   = 1'b1;
      bin_val = 6'd37;
      wstart  = 1'b1;
      wbin    = 14'd4321;
      @(posedge clk);
      #1;
      start  = 1'b0;
      wstart = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      for (int c = 0; c < 5; c++) begin
         e_seg = '0;
         for (int k = 0; k < int'(cfg_nd[c]); k++) e_seg[7*k +: 7] = cfg_al[c] ? 7'h7f : 7'h00;
         n_cmp++;
         if (a_busy[c] !== 1'b0 || a_done[c] !== 1'b0 || a_ovf[c] !== 1'b0 ||
             a_bcd[c] !== 20'h0 || a_seg[c] !== e_seg) begin
            n_bad++;
            $display("FAIL mid_reset cfg%0d: busy=%b done=%b ovf=%b bcd=%h seg=%b, want 0 0 0 0 %b",
                     c, a_busy[c], a_done[c], a_ovf[c], a_bcd[c], a_seg[c], e_seg);
         end
      end
      seen = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (a_done != 5'h0) seen++;
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (a_done != 5'h0) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_bad++;
         $display("FAIL mid_reset_done: done pulses=%0d, want 0", seen);
      end
      @(negedge clk);
      do_conv(1'b0, 59, lat, bs);
      for (int c = 0; c < 4; c++) begin
         model(59, cfg_nd[c], cfg_al[c], cfg_lb[c], e_bcd, e_seg, e_ovf);
         n_cmp++;
         if (lat != 7 || a_bcd[c] !== e_bcd || a_seg[c] !== e_seg || a_ovf[c] !== e_ovf) begin
            n_bad++;
            $display("FAIL post_reset cfg%0d: lat=%0d bcd=%h seg=%b ovf=%b, want 7 %h %b %b", c,
                     lat, a_bcd[c], a_seg[c], a_ovf[c], e_bcd, e_seg, e_ovf);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_start_ignored();
      test_random();
      test_wide();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
